// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// default geometry and the saturating counter helpers.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_t;

   localparam int         IDX_W_DEF    = 10;
   localparam int         GHR_W_DEF    = 8;
   localparam logic [1:0] CNT_INIT_DEF = WNT;

   // Count towards strongly-taken, holding at the top instead of wrapping.
   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? c : c + 2'd1;
   endfunction

   // Count towards strongly-not-taken, holding at the bottom instead of wrapping.
   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: one 2-bit counter per entry, a combinational read
// port for the fetch lookup and a clocked write port for training.
module bp_pht
   import branch_predictor_pkg::*;
#(
   parameter int         IDX_W    = IDX_W_DEF,
   parameter logic [1:0] CNT_INIT = CNT_INIT_DEF
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [1:0]       wr_cnt
);

   logic [1:0] cnt [2**IDX_W];

   // The read sees the array before this cycle's write lands, so a lookup of
   // the entry being trained returns the old counter.
   assign rd_cnt = cnt[rd_idx];

   // Every counter returns to its initial strength on reset; otherwise one entry is trained per cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 2**IDX_W; i++) begin
            cnt[i] <= CNT_INIT;
         end
      end else if (wr_en) begin
         cnt[wr_idx] <= wr_cnt;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor: looks up the PHT with PC xor global history in F,
// presents the prediction in D, and trains / repairs history when the branch
// resolves in E.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         IDX_W    = IDX_W_DEF,
   parameter int         GHR_W    = GHR_W_DEF,
   parameter logic [1:0] CNT_INIT = CNT_INIT_DEF
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pcF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        stallE,
   input  logic        flushE,
   input  logic        branchD,
   input  logic        branchE,
   input  logic        actual_takeE,
   output logic        pred_takeD,
   output logic        succE
);

   logic [GHR_W-1:0] ghr;
   logic [IDX_W-1:0] idx_f;
   logic [1:0]       cnt_f;

   logic [IDX_W-1:0] idx_d;
   logic [GHR_W-1:0] ghr_d;
   logic [1:0]       cnt_d;

   logic [IDX_W-1:0] idx_e;
   logic [GHR_W-1:0] ghr_e;
   logic             pred_e;
   logic [1:0]       cnt_e;

   logic             train_e;
   logic             mispred_e;
   logic [1:0]       new_cnt;
   logic             unused_bits;

   assign idx_f       = pcF[IDX_W+1:2] ^ IDX_W'(ghr);
   assign pred_takeD  = cnt_d[1] & branchD;
   assign succE       = !branchE | (pred_e == actual_takeE);
   assign train_e     = branchE & !stallE;
   assign mispred_e   = branchE & !succE & !stallE;
   assign unused_bits = ^{pcF[31:IDX_W+2], pcF[1:0], ghr_e[GHR_W-1]};

   bp_pht #(
      .IDX_W    (IDX_W),
      .CNT_INIT (CNT_INIT)
   ) u_pht (
      .clk    (clk),
      .resetn (resetn),
      .rd_idx (idx_f),
      .rd_cnt (cnt_f),
      .wr_en  (train_e),
      .wr_idx (idx_e),
      .wr_cnt (new_cnt)
   );

   // Move the resolved branch's counter one step toward its actual direction.
   always_comb begin
      new_cnt = cnt_e;
      if (actual_takeE) begin
         new_cnt = sat_inc(cnt_e);
      end else begin
         new_cnt = sat_dec(cnt_e);
      end
   end

   // Global history: a mispredict rebuilds it from the E branch's snapshot, which overrides the speculative D shift.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ghr <= '0;
      end else if (mispred_e) begin
         ghr <= {ghr_e[GHR_W-2:0], actual_takeE};
      end else if (branchD && !stallD) begin
         ghr <= {ghr[GHR_W-2:0], pred_takeD};
      end
   end

   // F->D register carries the lookup result and the history it was made with; a flush beats a stall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_d <= '0;
         ghr_d <= '0;
         cnt_d <= '0;
      end else if (flushD) begin
         idx_d <= '0;
         ghr_d <= '0;
         cnt_d <= '0;
      end else if (!stallD) begin
         idx_d <= idx_f;
         ghr_d <= ghr;
         cnt_d <= cnt_f;
      end
   end

   // D->E register keeps what training and recovery need when the branch resolves; a flush beats a stall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_e  <= '0;
         ghr_e  <= '0;
         pred_e <= 1'b0;
         cnt_e  <= '0;
      end else if (flushE) begin
         idx_e  <= '0;
         ghr_e  <= '0;
         pred_e <= 1'b0;
         cnt_e  <= '0;
      end else if (!stallE) begin
         idx_e  <= idx_d;
         ghr_e  <= ghr_d;
         pred_e <= pred_takeD;
         cnt_e  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for the gshare predictor: a cycle-level behavioural
// model is compared against the DUT on every negative clock edge, and the
// directed scenarios add hand-computed literal expectations.
module tb_branch_predictor;

   logic        clk;
   logic        resetn;
   logic [31:0] pcF;
   logic        stallD;
   logic        flushD;
   logic        stallE;
   logic        flushE;
   logic        branchD;
   logic        branchE;
   logic        actual_takeE;
   logic        pred_takeD;
   logic        succE;

   int passCount;
   int totalCount;
   bit checking;
   int obsPred;
   int obsSucc;
   int predSeen;

   int m_pht [1024];
   int m_ghr;
   int d_idx, d_hist, d_cnt;
   int e_idx, e_hist, e_cnt, e_pred;

   branch_predictor dut (
      .clk          (clk),
      .resetn       (resetn),
      .pcF          (pcF),
      .stallD       (stallD),
      .flushD       (flushD),
      .stallE       (stallE),
      .flushE       (flushE),
      .branchD      (branchD),
      .branchE      (branchE),
      .actual_takeE (actual_takeE),
      .pred_takeD   (pred_takeD),
      .succE        (succE)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      totalCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 1024; i++) m_pht[i] = 1;
      m_ghr  = 0;
      d_idx  = 0; d_hist = 0; d_cnt = 0;
      e_idx  = 0; e_hist = 0; e_cnt = 0; e_pred = 0;
   endtask

   // One clock of the predictor's architectural behaviour, from its rules:
   // strength counters 0..3, history as an 8-bit shift number, index = word address mod 1024 xor history.
   task automatic modelStep();
      int  fIdx;
      int  fCnt;
      int  pred;
      int  oldGhr;
      bit  mis;
      pred   = (branchD && d_cnt >= 2) ? 1 : 0;
      mis    = branchE && !stallE && (e_pred != int'(actual_takeE));
      oldGhr = m_ghr;
      fIdx   = int'((pcF >> 2) % 32'd1024) ^ m_ghr;
      fCnt   = m_pht[fIdx];
      if (branchE && !stallE) begin
         if (actual_takeE) m_pht[e_idx] = (e_cnt == 3) ? 3 : e_cnt + 1;
         else              m_pht[e_idx] = (e_cnt == 0) ? 0 : e_cnt - 1;
      end
      if (mis)                       m_ghr = (e_hist * 2 + int'(actual_takeE)) % 256;
      else if (branchD && !stallD)   m_ghr = (m_ghr * 2 + pred) % 256;
      if (flushE) begin
         e_idx = 0; e_hist = 0; e_cnt = 0; e_pred = 0;
      end else if (!stallE) begin
         e_idx = d_idx; e_hist = d_hist; e_cnt = d_cnt; e_pred = pred;
      end
      if (flushD) begin
         d_idx = 0; d_hist = 0; d_cnt = 0;
      end else if (!stallD) begin
         d_idx = fIdx; d_hist = oldGhr; d_cnt = fCnt;
      end
   endtask

   // Fetch address in the 0xBFC0_0000 region that lands on the given PHT entry under the current history.
   function automatic logic [31:0] pcForIdx(input int idx);
      logic [31:0] p;
      p       = 32'hBFC0_0000;
      p[11:2] = 10'(idx ^ m_ghr);
      return p;
   endfunction

   // Drive one clock's worth of inputs, record the mid-cycle outputs, then advance the model.
   task automatic applyStimulus(input logic [31:0] pc, input logic bD, input logic bE, input logic act,
                                input logic sD, input logic fD, input logic sE, input logic fE);
      pcF = pc; branchD = bD; branchE = bE; actual_takeE = act;
      stallD = sD; flushD = fD; stallE = sE; flushE = fE;
      @(negedge clk);
      #1;
      obsPred = int'(pred_takeD);
      obsSucc = int'(succE);
      @(posedge clk);
      modelStep();
      #1;
   endtask

   // One isolated branch: lookup in F, predict in D (then squash the wrong-path fetch), resolve in E.
   task automatic trainOnce(input int idx, input logic act, output int seen);
      applyStimulus(pcForIdx(idx), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      seen = obsPred;
      applyStimulus(32'h0,         1'b0, 1'b1, act,  1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Every cycle the predictor's outputs and history must match the model.
   always @(negedge clk) begin
      #1;
      if (checking) begin
         checkOutput("pred_takeD", int'(pred_takeD), (branchD && d_cnt >= 2) ? 1 : 0);
         checkOutput("succE", int'(succE), (!branchE || e_pred == int'(actual_takeE)) ? 1 : 0);
         checkOutput("ghr", int'(dut.ghr), m_ghr);
      end
   end

   initial begin
      logic [7:0] ghrBits;
      int         badCount;
      passCount  = 0;
      totalCount = 0;
      ghrBits    = 8'h5A;
      pcF = 32'h0; branchD = 0; branchE = 0; actual_takeE = 0;
      stallD = 0; flushD = 0; stallE = 0; flushE = 0;
      resetn = 1'b0;
      resetModel();
      checking = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_cnt_040", int'(dut.u_pht.cnt[64]), 1);
      resetn = 1'b1;

      $display("[TB] training: taken branch at 0xBFC0_0100");
      trainOnce(32'h040, 1'b1, predSeen);
      checkOutput("train1_pred", predSeen, 0);
      checkOutput("train1_cnt", int'(dut.u_pht.cnt[64]), 2);
      trainOnce(32'h040, 1'b1, predSeen);
      checkOutput("train2_cnt", int'(dut.u_pht.cnt[64]), 3);
      trainOnce(32'h040, 1'b1, predSeen);
      checkOutput("train3_cnt", int'(dut.u_pht.cnt[64]), 3);
      trainOnce(32'h040, 1'b1, predSeen);
      checkOutput("train4_pred", predSeen, 1);

      $display("[TB] saturation low: not-taken at entry 0x123");
      trainOnce(32'h123, 1'b0, predSeen);
      checkOutput("satlo1_cnt", int'(dut.u_pht.cnt[291]), 0);
      trainOnce(32'h123, 1'b0, predSeen);
      trainOnce(32'h123, 1'b0, predSeen);
      checkOutput("satlo3_cnt", int'(dut.u_pht.cnt[291]), 0);
      checkOutput("satlo3_pred", predSeen, 0);

      $display("[TB] building history 0x5A");
      for (int b = 7; b >= 0; b--) begin
         trainOnce(32'h200, ghrBits[b], predSeen);
      end
      checkOutput("ghr_built", int'(dut.ghr), 32'h5A);

      $display("[TB] mispredict recovery");
      applyStimulus(pcForIdx(32'h0FF), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(pcForIdx(32'h040), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("recov_predD", obsPred, 0);
      checkOutput("recov_ghr_spec", int'(dut.ghr), 32'hB4);
      applyStimulus(32'h0,             1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("recov_coincident_predD", obsPred, 1);
      checkOutput("recov_succE", obsSucc, 0);
      checkOutput("recov_ghr", int'(dut.ghr), 32'hB5);

      $display("[TB] stallE hold on a resolving branch");
      applyStimulus(pcForIdx(32'h155), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h0,             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_ghr_pre", int'(dut.ghr), 32'h6A);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput("stall_cnt_held", int'(dut.u_pht.cnt[341]), 1);
         checkOutput("stall_ghr_held", int'(dut.ghr), 32'h6A);
      end
      applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("stall_cnt_release", int'(dut.u_pht.cnt[341]), 2);
      checkOutput("stall_ghr_release", int'(dut.ghr), 32'h6B);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("stall_cnt_once", int'(dut.u_pht.cnt[341]), 2);

      $display("[TB] same-cycle read and write of entry 0x3F3");
      applyStimulus(pcForIdx(32'h3F3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h0,             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(pcForIdx(32'h3F3), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("samecyc_cnt", int'(dut.u_pht.cnt[1011]), 2);
      applyStimulus(32'h0,             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("samecyc_old_pred", obsPred, 0);
      applyStimulus(pcForIdx(32'h3F3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h0,             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("samecyc_new_pred", obsPred, 1);

      $display("[TB] mixed stall/flush traffic");
      for (int n = 0; n < 80; n++) begin
         applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 5) == 0));
      end

      $display("[TB] reset pulse mid-run");
      applyStimulus(pcForIdx(32'h040), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      resetn = 1'b0;
      resetModel();
      #1;
      checkOutput("midreset_pred", int'(pred_takeD), 0);
      checkOutput("midreset_succ", int'(succE), 1);
      checkOutput("midreset_ghr", int'(dut.ghr), 0);
      badCount = 0;
      for (int i = 0; i < 1024; i++) begin
         if (dut.u_pht.cnt[i] != 2'b01) badCount++;
      end
      checkOutput("midreset_pht_bad", badCount, 0);
      branchD = 1'b0;
      @(posedge clk);
      #2;
      resetn = 1'b1;
      trainOnce(32'h040, 1'b1, predSeen);
      checkOutput("postreset_pred", predSeen, 0);
      checkOutput("postreset_cnt", int'(dut.u_pht.cnt[64]), 2);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      checking = 1'b0;
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
